// File: rtl/morra_cinese.sv
// Purpose: referee for a two-player rock-paper-scissors match. It loads the match length,
//          validates and scores each round, and declares the match result.
// Latency: 1 cycle. MANCHE and PARTITA are registered and reflect the inputs sampled at the previous edge.
// Backpressure: none. One round is accepted per clock with no handshake.
// Ports: clk, rst_n (async, active low); PRIMO/SECONDO moves (length setting on a start cycle);
//        INIZIA start/restart; MANCHE round result; PARTITA match result (one-cycle pulse).
module morra_cinese (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] PRIMO,
    input  logic [1:0] SECONDO,
    input  logic       INIZIA,
    output logic [1:0] MANCHE,
    output logic [1:0] PARTITA
);

    typedef enum logic {
        IDLE = 1'b0,
        PLAY = 1'b1
    } state_t;

    localparam logic [1:0] ROCK     = 2'b01;
    localparam logic [1:0] PAPER    = 2'b10;
    localparam logic [1:0] SCISSORS = 2'b11;

    state_t     state;
    logic [4:0] maxm;
    logic [4:0] nman;
    logic [4:0] w1;
    logic [4:0] w2;
    logic       lw_vld;     // a winner restriction is active
    logic       lw_p2;      // 0: player 1 won last, 1: player 2 won last
    logic [1:0] lw_move;    // move the last winner won with

    // Round evaluation
    logic       moves_ok;
    logic       repeat_blk;
    logic       round_ok;
    logic       p1_beats;
    logic       p2_beats;
    logic [4:0] nman_nx;
    logic [4:0] w1_nx;
    logic [4:0] w2_nx;
    logic [1:0] end_res;

    always_comb begin
        moves_ok = (PRIMO != 2'b00) && (SECONDO != 2'b00);

        // The last winner may not reuse the move it won with.
        repeat_blk = 1'b0;
        if (lw_vld) begin
            repeat_blk = lw_p2 ? (SECONDO == lw_move) : (PRIMO == lw_move);
        end

        round_ok = moves_ok && !repeat_blk;

        p1_beats = ((PRIMO == ROCK)     && (SECONDO == SCISSORS)) ||
                   ((PRIMO == SCISSORS) && (SECONDO == PAPER))    ||
                   ((PRIMO == PAPER)    && (SECONDO == ROCK));
        p2_beats = ((SECONDO == ROCK)     && (PRIMO == SCISSORS)) ||
                   ((SECONDO == SCISSORS) && (PRIMO == PAPER))    ||
                   ((SECONDO == PAPER)    && (PRIMO == ROCK));

        nman_nx = nman + 5'd1;
        w1_nx   = p1_beats ? w1 + 5'd1 : w1;
        w2_nx   = p2_beats ? w2 + 5'd1 : w2;

        // Match end is judged on the counts including this round.
        // Counts never exceed 19, so +2 stays within 5 bits.
        end_res = 2'b00;
        if ((nman_nx >= 5'd4) && (w1_nx >= w2_nx + 5'd2)) begin
            end_res = 2'b01;
        end else if ((nman_nx >= 5'd4) && (w2_nx >= w1_nx + 5'd2)) begin
            end_res = 2'b10;
        end else if (nman_nx == maxm) begin
            if (w1_nx > w2_nx) begin
                end_res = 2'b01;
            end else if (w2_nx > w1_nx) begin
                end_res = 2'b10;
            end else begin
                end_res = 2'b11;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            maxm    <= 5'd0;
            nman    <= 5'd0;
            w1      <= 5'd0;
            w2      <= 5'd0;
            lw_vld  <= 1'b0;
            lw_p2   <= 1'b0;
            lw_move <= 2'b00;
            MANCHE  <= 2'b00;
            PARTITA <= 2'b00;
        end else begin
            MANCHE  <= 2'b00;
            PARTITA <= 2'b00;
            if (INIZIA) begin
                // Start/restart wins over everything and silently drops any running match.
                maxm    <= 5'd4 + {1'b0, PRIMO, SECONDO};
                nman    <= 5'd0;
                w1      <= 5'd0;
                w2      <= 5'd0;
                lw_vld  <= 1'b0;
                lw_p2   <= 1'b0;
                lw_move <= 2'b00;
                state   <= PLAY;
            end else begin
                case (state)
                    PLAY: begin
                        if (round_ok) begin
                            nman <= nman_nx;
                            w1   <= w1_nx;
                            w2   <= w2_nx;
                            if (p1_beats) begin
                                MANCHE  <= 2'b01;
                                lw_vld  <= 1'b1;
                                lw_p2   <= 1'b0;
                                lw_move <= PRIMO;
                            end else if (p2_beats) begin
                                MANCHE  <= 2'b10;
                                lw_vld  <= 1'b1;
                                lw_p2   <= 1'b1;
                                lw_move <= SECONDO;
                            end else begin
                                // A tie lifts the repeat restriction.
                                MANCHE  <= 2'b11;
                                lw_vld  <= 1'b0;
                            end
                            PARTITA <= end_res;
                            if (end_res != 2'b00) begin
                                state <= IDLE;
                            end
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_morra_cinese.sv
module tb_morra_cinese;

    logic       clk;
    logic       rst_n;
    logic [1:0] PRIMO;
    logic [1:0] SECONDO;
    logic       INIZIA;
    logic [1:0] MANCHE;
    logic [1:0] PARTITA;

    int checks;
    int failures;

    morra_cinese dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .PRIMO   (PRIMO),
        .SECONDO (SECONDO),
        .INIZIA  (INIZIA),
        .MANCHE  (MANCHE),
        .PARTITA (PARTITA)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       ini;
        logic [1:0] p1;
        logic [1:0] p2;
        logic [1:0] em;
        logic [1:0] ep;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [1:0] m_exp, input logic [1:0] p_exp);
        checks++;
        if (MANCHE !== m_exp || PARTITA !== p_exp) begin
            failures++;
            $display("FAIL %s: got MANCHE=%b PARTITA=%b, expected MANCHE=%b PARTITA=%b",
                     name, MANCHE, PARTITA, m_exp, p_exp);
        end
    endtask

    // Drive inputs just after an edge, let the next rising edge sample them, check 1 time unit later.
    task automatic step(input logic ini, input logic [1:0] p1, input logic [1:0] p2,
                        input logic [1:0] em, input logic [1:0] ep, input string name);
        INIZIA  = ini;
        PRIMO   = p1;
        SECONDO = p2;
        @(posedge clk);
        #1;
        check(name, em, ep);
    endtask

    task automatic add(input logic ini, input logic [1:0] p1, input logic [1:0] p2,
                       input logic [1:0] em, input logic [1:0] ep);
        vec_t v;
        v.ini = ini; v.p1 = p1; v.p2 = p2; v.em = em; v.ep = ep;
        vecs.push_back(v);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        INIZIA   = 1'b0;
        PRIMO    = 2'b00;
        SECONDO  = 2'b00;

        // Length 13 then abort with restart to maxm=6
        add(1, 2'b10, 2'b01, 2'b00, 2'b00);
        add(0, 2'b01, 2'b10, 2'b10, 2'b00);
        add(0, 2'b01, 2'b01, 2'b11, 2'b00);
        add(1, 2'b00, 2'b10, 2'b00, 2'b00);
        // Invalid rounds and early lead within maxm=6
        add(0, 2'b00, 2'b10, 2'b00, 2'b00);
        add(0, 2'b01, 2'b11, 2'b01, 2'b00);
        add(0, 2'b10, 2'b01, 2'b01, 2'b00);
        add(0, 2'b01, 2'b10, 2'b10, 2'b00);
        add(0, 2'b10, 2'b10, 2'b00, 2'b00);
        add(0, 2'b11, 2'b11, 2'b11, 2'b00);
        add(0, 2'b10, 2'b01, 2'b01, 2'b01);
        add(0, 2'b01, 2'b11, 2'b00, 2'b00);   // idle after end
        // Draw at max, maxm=4
        add(1, 2'b00, 2'b00, 2'b00, 2'b00);
        add(0, 2'b11, 2'b11, 2'b11, 2'b00);
        add(0, 2'b01, 2'b11, 2'b01, 2'b00);
        add(0, 2'b10, 2'b11, 2'b10, 2'b00);
        add(0, 2'b00, 2'b01, 2'b00, 2'b00);
        add(0, 2'b01, 2'b11, 2'b00, 2'b00);
        add(0, 2'b01, 2'b01, 2'b11, 2'b11);
        add(0, 2'b01, 2'b11, 2'b00, 2'b00);
        // Max-length decision by score, maxm=4
        add(1, 2'b00, 2'b00, 2'b00, 2'b00);
        add(0, 2'b01, 2'b11, 2'b01, 2'b00);
        add(0, 2'b10, 2'b10, 2'b11, 2'b00);
        add(0, 2'b11, 2'b11, 2'b11, 2'b00);
        add(0, 2'b01, 2'b01, 2'b11, 2'b01);
        add(0, 2'b01, 2'b11, 2'b00, 2'b00);
        // Player 2 by lead in a maxm=19 match; no end at 2-0
        add(1, 2'b11, 2'b11, 2'b00, 2'b00);
        add(0, 2'b11, 2'b01, 2'b10, 2'b00);
        add(0, 2'b01, 2'b10, 2'b10, 2'b00);
        add(0, 2'b10, 2'b11, 2'b10, 2'b00);
        add(0, 2'b11, 2'b01, 2'b10, 2'b10);
        add(0, 2'b11, 2'b01, 2'b00, 2'b00);

        // Reset state
        #12;
        check("reset_state", 2'b00, 2'b00);
        @(negedge clk);
        rst_n = 1'b1;
        step(0, 2'b01, 2'b11, 2'b00, 2'b00, "idle_after_reset");

        foreach (vecs[i]) begin
            step(vecs[i].ini, vecs[i].p1, vecs[i].p2, vecs[i].em, vecs[i].ep,
                 $sformatf("vec%0d", i));
        end

        // Async reset mid-match: outputs clear at once, moves ignored until restart.
        step(1, 2'b00, 2'b00, 2'b00, 2'b00, "ar_start");
        step(0, 2'b01, 2'b11, 2'b01, 2'b00, "ar_round");
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_immediate", 2'b00, 2'b00);
        #1;
        rst_n = 1'b1;
        step(0, 2'b01, 2'b11, 2'b00, 2'b00, "ar_ignored");
        step(0, 2'b10, 2'b01, 2'b00, 2'b00, "ar_ignored2");
        // Fresh match after reset: the earlier P1 rock win must not block rock.
        step(1, 2'b00, 2'b00, 2'b00, 2'b00, "ar_restart");
        step(0, 2'b01, 2'b11, 2'b01, 2'b00, "ar_r1");
        step(0, 2'b10, 2'b01, 2'b01, 2'b00, "ar_r2");
        step(0, 2'b11, 2'b10, 2'b01, 2'b00, "ar_r3");
        step(0, 2'b01, 2'b11, 2'b01, 2'b01, "ar_r4_lead");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/morra_cinese.md
# morra_cinese

Sequential referee for a two-player rock-paper-scissors ("morra cinese") match. It configures match length at start, validates and scores each round (manche), and declares the match (partita) result. It is a standalone FSMD: synchronous control FSM plus counters, one clock domain.

## Interface
- No parameters.
- `clk` input 1: system clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `PRIMO` input 2: player 1 move: 01 rock, 10 paper, 11 scissors, 00 invalid. During a start cycle it is the high half of the length setting.
- `SECONDO` input 2: player 2 move, same encoding. During a start cycle it is the low half of the length setting.
- `INIZIA` input 1: start or restart a match.
- `MANCHE` output 2: round result: 00 not counted, 01 player 1 wins, 10 player 2 wins, 11 tie.
- `PARTITA` output 2: match result: 00 match running or idle, 01 player 1 wins, 10 player 2 wins, 11 draw.

## Operation
- States:
  - IDLE: after reset, or after a match has ended.
  - PLAY: match in progress.
- Datapath registers:
  - `maxm`, 5 bits.
  - `nman`, round count, 5 bits.
  - `w1`, `w2`, win counts, 5 bits each.
  - `last_win`: player id and that player's winning move, with a valid flag.
- `INIZIA=1` has top priority in any state:
  - Load `maxm` = 4 + {PRIMO,SECONDO}, an unsigned 4-bit value, giving a range of 4..19.
  - Clear `nman`, `w1`, `w2` and `last_win`.
  - Go to PLAY.
  - Outputs MANCHE=00, PARTITA=00.
- In IDLE with `INIZIA=0`: inputs are ignored and outputs are 00/00.
- In PLAY with `INIZIA=0`, a round is invalid when either of these holds:
  - either move is 00;
  - `last_win` is valid and the previous valid round's winner plays the same move it won with.
- Invalid round:
  - MANCHE=00, PARTITA=00.
  - No counter changes; `last_win` is kept.
- Valid round:
  - Rules: rock beats scissors, scissors beats paper, paper beats rock.
  - Increment `nman`.
  - Player 1 wins: increment `w1`, MANCHE=01, `last_win` = (P1, its move).
  - Player 2 wins: increment `w2`, MANCHE=10, `last_win` = (P2, its move).
  - Equal moves: MANCHE=11; `last_win` is cleared, so no restriction applies to the next round.
- Match end is evaluated on the updated counts:
  - If `nman` ≥ 4 and |w1−w2| ≥ 2: the leader wins (PARTITA 01/10).
  - Else if `nman` == `maxm`: the match is decided by score (w1>w2 gives 01, w2>w1 gives 10, equal gives 11).
  - Otherwise PARTITA=00.
  - On any end, go to IDLE.
- A lead of 2 or more before 4 valid rounds does not end the match.

## Timing
- Inputs are sampled on the rising edge of `clk`.
- MANCHE and PARTITA are registered. They show the result of the inputs sampled at edge k from edge k until edge k+1, so latency is 1 cycle.
- A nonzero PARTITA lasts exactly one cycle. The next cycle, in IDLE, outputs 00/00 unless `INIZIA=1`.
- Reset (`rst_n=0`, at any time including mid-match):
  - Immediately forces IDLE.
  - MANCHE=00, PARTITA=00.
  - All counters cleared, `last_win` invalid.
- Restart mid-match: `INIZIA=1` discards the current match. No PARTITA is issued for the aborted match.
- One round per clock; there is no handshake.
- Counters never exceed 19.

## Test plan
- Length 13, abort: reset, then INIZIA=1 with 10/01. Then 01/10 gives MANCHE=10. Then 01/01 gives MANCHE=11, PARTITA=00. Then INIZIA=1 with 00/10 restarts with maxm=6 and outputs 00/00.
- Invalid and early lead, in a match with maxm=6:
  - 00/10 gives MANCHE=00.
  - 01/11 gives 01.
  - 10/01 gives 01, PARTITA=00 (2-0 lead after 2 rounds).
  - 01/10 gives 10.
  - 10/10 gives 00, because player 2 repeats its winning paper.
  - 11/11 gives 11.
  - 10/01 gives MANCHE=01, PARTITA=01 (3-1 after 5 rounds).
- Draw at max, with INIZIA 00/00 (maxm=4):
  - 11/11 gives 11.
  - 01/11 gives 01.
  - 10/11 gives 10.
  - 00/01 gives 00.
  - 01/11 gives 00, because player 2 repeats scissors.
  - 01/01 gives MANCHE=11, PARTITA=11.
- Post-end idle: after any PARTITA≠00, apply 01/11 with INIZIA=0 and expect 00/00 with no counting.
- Max-length decision: maxm=4 with rounds P1, tie, tie, tie gives PARTITA=01 on the 4th round.
- Async reset mid-match: pulse rst_n low between edges, expect outputs 00 immediately and further moves ignored until INIZIA.
